// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: state encoding,
// bit-order constants and a constant clog2 helper.
package spi_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACTIVE = ACTIVE,
        ST_DONE   = DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Received-bit counter: cleared on frame start, advanced per sample
// strobe, flags the last bit of the frame when cnt == len.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int LEN_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [LEN_W-1:0] cnt_o,
    output logic             term_o
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == len_i);

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine driven by SCLK-generator strobes.
// Define SPI_SHIFT_LOOPBACK_EN to add the i_loopback port (RX samples o_mosi).
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int LEN_W = clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_lsb_first,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic              i_loopback,
`endif
    input  logic              i_shift_stb,
    input  logic              i_sample_stb,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data
);

    state_e            state_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rx_d;
    logic [DATA_W-1:0] rx_mask;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  ptr_q;
    logic [LEN_W-1:0]  ptr_d;
    logic [LEN_W-1:0]  cnt;
    logic              lsb_q;
    logic              last_tx;
    logic              cnt_term;
    logic              samp_bit;
    logic              o_mosi_q;
    logic              o_busy_q;
    logic              o_done_q;
    logic [DATA_W-1:0] o_rx_data_q;

`ifdef SPI_SHIFT_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lb_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_start) begin
            lb_q <= i_loopback;
        end
    end

    assign samp_bit = lb_q ? o_mosi_q : i_miso;
`else
    assign samp_bit = i_miso;
`endif

    spi_bit_counter #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr_i   (state_q == ST_IDLE && i_start),
        .en_i    (state_q == ST_ACTIVE && i_sample_stb),
        .len_i   (len_q),
        .cnt_o   (cnt),
        .term_o  (cnt_term)
    );

    always_comb begin
        rx_d = rx_q;
        if (lsb_q == LSB_FIRST) begin
            rx_d[cnt] = samp_bit;
        end else begin
            rx_d = {rx_q[DATA_W-2:0], samp_bit};
        end
        for (int i = 0; i < DATA_W; i++) begin
            rx_mask[i] = (i <= int'(len_q));
        end
        last_tx = (lsb_q == LSB_FIRST) ? (ptr_q == len_q) : (ptr_q == '0);
        ptr_d   = (lsb_q == LSB_FIRST) ? ptr_q + 1'b1 : ptr_q - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            len_q       <= '0;
            ptr_q       <= '0;
            lsb_q       <= 1'b0;
            o_mosi_q    <= 1'b0;
            o_busy_q    <= 1'b0;
            o_done_q    <= 1'b0;
            o_rx_data_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q  <= ST_ACTIVE;
                        tx_q     <= i_tx_data;
                        len_q    <= i_len;
                        lsb_q    <= i_lsb_first;
                        rx_q     <= '0;
                        o_busy_q <= 1'b1;
                        ptr_q    <= (i_lsb_first == MSB_FIRST) ? i_len : '0;
                        o_mosi_q <= (i_lsb_first == MSB_FIRST) ?
                                    i_tx_data[i_len] : i_tx_data[0];
                    end
                end
                ST_ACTIVE: begin
                    if (i_sample_stb) begin
                        rx_q <= rx_d;
                        if (cnt_term) begin
                            state_q     <= ST_DONE;
                            o_done_q    <= 1'b1;
                            o_rx_data_q <= rx_d & rx_mask;
                        end
                    end
                    // pointer parks on the last bit so late shifts hold o_mosi
                    if (i_shift_stb && !last_tx) begin
                        ptr_q    <= ptr_d;
                        o_mosi_q <= tx_q[ptr_d];
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    o_done_q <= 1'b0;
                    o_busy_q <= 1'b0;
                    o_mosi_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mosi    = o_mosi_q;
    assign o_busy    = o_busy_q;
    assign o_done    = o_done_q;
    assign o_rx_data = o_rx_data_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised full-duplex serial shift engine for the SPI controller datapath. It supersedes the fixed 8-bit universal shift register. Features:
- Configurable frame length (1..DATA_W bits) and run-time MSB/LSB-first bit order.
- Explicit start/busy/done handshake.
- Shifts on one-cycle strobes from the SCLK generator, so all logic runs on i_clk with no derived clocks.

Parameters:
DATA_W, 8, maximum frame width in bits (>=2)
LEN_W, $clog2(DATA_W), width of i_len; localparam, not overridable

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle frame request; accepted only in IDLE
i_tx_data  in  DATA_W  transmit word; latched on accepted i_start
i_len  in  LEN_W  frame length minus 1; latched on accepted i_start
i_lsb_first  in  1  bit order (1 = LSB first); latched on accepted i_start
i_shift_stb  in  1  launch-edge strobe; advances TX bit
i_sample_stb  in  1  capture-edge strobe; samples i_miso
i_miso  in  1  serial input
o_mosi  out  1  serial output
o_busy  out  1  high while a frame is in progress
o_done  out  1  one-cycle pulse at frame end
o_rx_data  out  DATA_W  received word, right-aligned; updated with o_done

Behaviour:
- Reset: all outputs are 0 (o_mosi, o_busy, o_done, o_rx_data); state = IDLE; the bit counter, TX register and RX register are cleared.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - o_busy=0, o_mosi=0, strobes ignored.
  - i_start=1 at cycle N latches tx/len/order and clears the counter and RX register.
  - At N+1: state=ACTIVE, o_busy=1, o_mosi = first bit.
  - First bit is i_tx_data[len] for MSB-first, i_tx_data[0] for LSB-first.
- ACTIVE:
  - i_sample_stb shifts i_miso into the RX register and increments the bit counter.
  - MSB-first: rx = {rx[DATA_W-2:0], miso}.
  - LSB-first: the bit is written at position cnt. Result is right-aligned with bit 0 = first received bit.
  - i_shift_stb advances the TX pointer; o_mosi shows the next bit from the cycle after the strobe.
  - Both strobes in the same cycle: the sample uses the pre-shift state and both actions apply.
  - A shift strobe after the last bit holds o_mosi at the last bit.
  - The sample strobe where cnt == len moves the state to DONE on the next edge.
- DONE (exactly one cycle):
  - o_done=1; o_rx_data loaded with the RX register, bits above len forced to 0.
  - o_busy=1, o_mosi holds the last bit.
  - Next state IDLE.
- o_rx_data holds its value until the next DONE.
- i_start during ACTIVE/DONE is ignored, with no queuing. i_start in the same cycle as DONE→IDLE is also ignored; a new start is accepted from the first IDLE cycle.
- Changes to i_tx_data/i_len/i_lsb_first mid-frame have no effect.
- i_len=0 gives a one-bit frame: a single sample strobe leads to DONE.
- Reset mid-frame aborts immediately: no o_done, o_rx_data cleared to 0.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
SPI_SHIFT_LOOPBACK_EN
- Defined:
  - Adds input i_loopback (1 bit), latched on accepted i_start.
  - When latched high, the RX path samples the internal o_mosi value instead of i_miso, and o_mosi is still driven.
- Undefined: the port is absent and i_miso is always sampled.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2);
  - a clog2 helper function;
  - bit-order constants MSB_FIRST=1'b0, LSB_FIRST=1'b1.
- One natural sub-module, spi_bit_counter: LEN_W counter with clear, enable on sample strobe, and a terminal flag when cnt == len.

Test Plan:
- DATA_W=8, len=7, MSB-first, tx 0xC1, miso driving 0x3C, 8 strobe pairs → mosi 1,1,0,0,0,0,0,1; o_done single pulse after 8th sample; o_rx_data=0x3C; o_busy falls one cycle after o_done.
- Same with i_lsb_first=1, tx 0xC1, miso bits 0,0,1,1,1,1,0,0 → mosi 1,0,0,0,0,0,1,1; o_rx_data=0x3C.
- Short frame len=3, MSB-first, tx 0x0B, miso 1,1,0,1 → mosi 1,0,1,1; o_rx_data=0x0D with upper bits 0; exactly 4 samples to o_done.
- i_start pulsed mid-frame with tx 0xFF → ignored, original frame completes unchanged; start on first IDLE cycle accepted.
- i_rst_n low after 3 samples → all outputs 0 asynchronously, no o_done; subsequent start with tx 0x5A completes correctly.
- Macro defined, i_loopback=1, tx 0xA7, simultaneous shift/sample strobes every 4 cycles → o_rx_data=0xA7 regardless of i_miso.
